tap_ctrl: RTL and testbench
===========================

# tap_ctrl

IEEE 1149.1-style TAP controller for the boundary-scan test datapath. It decodes TMS into the 16-state TAP FSM, holds a 3-bit instruction register, and contains the bypass and IDCODE data registers. It drives the capture/shift/update strobes and the test-mode enable for the external boundary-scan register (BSR) and internal scan chain, and multiplexes their serial outputs onto TDO. It sits between the chip test pins and the scan datapath.

## Interface
- IDCODE — default 8'hA5 — 8-bit device ID loaded into the IDCODE register on Capture-DR.
- CK — in — 1 — test clock; all state changes on the rising edge.
- TRST_b — in — 1 — asynchronous, active-low reset.
- TMS — in — 1 — test mode select, sampled on the CK rising edge.
- TDI — in — 1 — serial test data in.
- bsr_tdo — in — 1 — serial out of the BSR chain.
- in_scan_tdo — in — 1 — serial out of the internal scan chain.
- TDO — out — 1 — serial test data out.
- bsr_capt — out — 1 — BSR capture enable.
- in_scan_capt — out — 1 — internal scan capture enable.
- shftdr — out — 1 — DR shift enable.
- updr — out — 1 — BSR update strobe.
- test_mode — out — 1 — scan datapath drives outputs from its update latches.

## Operation
- FSM states and encodings: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
- Transitions follow the 1149.1 TMS graph.
  - TLR: TMS=0 → RTI.
  - RTI and UpdDR/UpdIR: TMS=1 → SelDR.
  - SelDR: TMS=1 → SelIR.
  - SelIR: TMS=1 → TLR.
  - Capture, Shift, Exit1, Pause and Exit2 follow the standard graph.
- Instruction opcodes: EXTEST=000, SAMPLE=001, INTSCAN=010, IDCODE=011, BYPASS=111. Unused codes 100–110 decode as BYPASS.
- IR shift register (ir_sr):
  - CapIR loads 3'b001.
  - ShIR shifts right; TDI enters the MSB.
  - UpdIR copies ir_sr into ir.
- DR selection by ir:
  - EXTEST and SAMPLE select the BSR.
  - INTSCAN selects the internal chain.
  - IDCODE selects the 8-bit idcode_sr: loaded with IDCODE in CapDR, shifted right in ShDR with TDI entering the MSB.
  - BYPASS selects the 1-bit bypass_ff: cleared in CapDR, loaded from TDI in ShDR.
- Output decode (combinational from state and ir):
  - bsr_capt = CapDR and ir ∈ {EXTEST, SAMPLE}.
  - in_scan_capt = CapDR and ir = INTSCAN.
  - shftdr = ShDR and ir ∈ {EXTEST, SAMPLE, INTSCAN}.
  - updr = UpdDR and ir ∈ {EXTEST, SAMPLE}.
  - test_mode = ir ∈ {EXTEST, INTSCAN}.
- TDO:
  - In ShIR: ir_sr[0].
  - In ShDR: the selected DR output (bsr_tdo, in_scan_tdo, idcode_sr[0] or bypass_ff).
  - Otherwise 0.
- Reset: TRST_b low asynchronously forces:
  - state=TLR, ir=IDCODE, ir_sr=001, bypass_ff=0, idcode_sr=IDCODE.
  - All strobes 0, test_mode=0, TDO=0.
- TLR (synchronous reset): entering TLR sets ir=IDCODE. Five consecutive TMS=1 edges from any state reach TLR.

## Timing
- Next-state logic is registered; outputs are Moore-decoded. Each strobe is high for exactly the cycles the FSM occupies its state.
  - The rising edge ending CapDR performs the capture.
  - Every edge while in ShDR shifts one bit.
- updr is a single-cycle pulse per pass through UpdDR.
- New ir takes effect on the edge leaving UpdIR. test_mode changes in the following cycle, not earlier.
- Shifting N bits through a DR of length L yields a TDI→TDO delay of L edges. Bypass gives 1 edge.
- TRST_b assertion mid-shift aborts the shift immediately:
  - Partial ir_sr contents are discarded.
  - ir is not updated.
  - No updr pulse is generated.
- TRST_b deassertion is taken synchronously to CK by the top-level; the block requires no TMS sampling on the release edge.

## Structure
- Package tap_pkg: state enum with the encodings above, opcode constants, IR_W=3.
- Sub-module tap_fsm: state register plus next-state logic only.
- Decode, IR, bypass, IDCODE and TDO mux live in tap_ctrl.

## Test plan
- Reset: pulse TRST_b low mid-operation → state TLR, all strobes 0, test_mode=0, ir=011. Then TMS=1 for 5 clocks from ShDR → TLR.
- IR capture: RTI→ShIR, shift in 3'b000 with TMS=1 on the last bit → TDO shows 1,0,0 (captured 001). After UpdIR, test_mode=1 from the next cycle.
- IDCODE: after reset, go to ShDR and shift 8 bits → TDO shows 8'hA5 LSB first.
- BYPASS: load 111, shift pattern 1011 → TDO shows 0,1,0,1,1 (captured 0 then TDI delayed 1 cycle). shftdr=0 throughout.
- EXTEST: load 000, run CapDR→ShDR×4→Ex1DR→UpdDR → bsr_capt high 1 cycle, shftdr high 4 cycles, updr high 1 cycle, TDO follows bsr_tdo during shift.
- INTSCAN with Pause: load 010, shift 2 bits, PauseDR 3 cycles, resume 1 bit → in_scan_capt high 1 cycle, shftdr low during PauseDR/Ex2DR, updr never asserted.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared types for the TAP controller: FSM state encodings, IR opcodes and
// the data-register selection derived from the current instruction.
package tap_pkg;

  localparam int IR_W = 3;

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  localparam logic [IR_W-1:0] OP_EXTEST  = 3'b000;
  localparam logic [IR_W-1:0] OP_SAMPLE  = 3'b001;
  localparam logic [IR_W-1:0] OP_INTSCAN = 3'b010;
  localparam logic [IR_W-1:0] OP_IDCODE  = 3'b011;
  localparam logic [IR_W-1:0] OP_BYPASS  = 3'b111;

  typedef enum logic [1:0] {
    DR_BSR,
    DR_INSCAN,
    DR_IDCODE,
    DR_BYPASS
  } dr_sel_t;

  // Debug view of the controller so checkers can bind without probing internals.
  typedef struct packed {
    tap_state_t      state;
    logic [IR_W-1:0] ir;
  } tap_dbg_t;

  // Unused opcodes 100..110 fall through to BYPASS.
  function automatic dr_sel_t decode_dr(input logic [IR_W-1:0] ir);
    dr_sel_t sel;
    case (ir)
      OP_EXTEST, OP_SAMPLE: sel = DR_BSR;
      OP_INTSCAN:           sel = DR_INSCAN;
      OP_IDCODE:            sel = DR_IDCODE;
      default:              sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/tap_ctrl_fsm.sv
// 16-state TAP state machine: state register and TMS-driven next-state logic.
import tap_pkg::*;

module tap_ctrl_fsm (
  input  logic       CK,
  input  logic       TRST_b,
  input  logic       TMS,
  output tap_state_t state,
  output tap_state_t next_state
);

  always_ff @(posedge CK or negedge TRST_b) begin
    if (!TRST_b) state <= TLR;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:      next_state = TMS ? TLR    : RTI;
      RTI:      next_state = TMS ? SEL_DR : RTI;
      SEL_DR:   next_state = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   next_state = TMS ? EX1_DR : SH_DR;
      SH_DR:    next_state = TMS ? EX1_DR : SH_DR;
      EX1_DR:   next_state = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: next_state = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   next_state = TMS ? UPD_DR : SH_DR;
      UPD_DR:   next_state = TMS ? SEL_DR : RTI;
      SEL_IR:   next_state = TMS ? TLR    : CAP_IR;
      CAP_IR:   next_state = TMS ? EX1_IR : SH_IR;
      SH_IR:    next_state = TMS ? EX1_IR : SH_IR;
      EX1_IR:   next_state = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: next_state = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   next_state = TMS ? UPD_IR : SH_IR;
      UPD_IR:   next_state = TMS ? SEL_DR : RTI;
      default:  next_state = TLR;
    endcase
  end

endmodule

// File: rtl/tap_ctrl.sv
// TAP controller top: instruction register, bypass and IDCODE registers,
// scan-strobe decode and the TDO multiplexer around the TAP state machine.
import tap_pkg::*;

module tap_ctrl #(
  parameter logic [7:0] IDCODE = 8'hA5
) (
  input  logic     CK,
  input  logic     TRST_b,
  input  logic     TMS,
  input  logic     TDI,
  input  logic     bsr_tdo,
  input  logic     in_scan_tdo,
  output logic     TDO,
  output logic     bsr_capt,
  output logic     in_scan_capt,
  output logic     shftdr,
  output logic     updr,
  output logic     test_mode,
  output tap_dbg_t dbg
);

  tap_state_t      state;
  tap_state_t      next_state;
  logic [IR_W-1:0] ir;
  logic [IR_W-1:0] ir_sr;
  logic            bypass_ff;
  logic [7:0]      idcode_sr;
  dr_sel_t         dr_sel;

  tap_ctrl_fsm u_fsm (
    .CK         (CK),
    .TRST_b     (TRST_b),
    .TMS        (TMS),
    .state      (state),
    .next_state (next_state)
  );

  assign dr_sel = decode_dr(ir);

  // Entering TLR wins over UpdIR so five TMS=1 edges always restore IDCODE.
  always_ff @(posedge CK or negedge TRST_b) begin
    if (!TRST_b) begin
      ir        <= OP_IDCODE;
      ir_sr     <= 3'b001;
      bypass_ff <= 1'b0;
      idcode_sr <= IDCODE;
    end else begin
      if (state == CAP_IR)     ir_sr <= 3'b001;
      else if (state == SH_IR) ir_sr <= {TDI, ir_sr[IR_W-1:1]};

      if (next_state == TLR)    ir <= OP_IDCODE;
      else if (state == UPD_IR) ir <= ir_sr;

      if (dr_sel == DR_BYPASS) begin
        if (state == CAP_DR)     bypass_ff <= 1'b0;
        else if (state == SH_DR) bypass_ff <= TDI;
      end

      if (dr_sel == DR_IDCODE) begin
        if (state == CAP_DR)     idcode_sr <= IDCODE;
        else if (state == SH_DR) idcode_sr <= {TDI, idcode_sr[7:1]};
      end
    end
  end

  always_comb begin
    bsr_capt     = (state == CAP_DR) && (dr_sel == DR_BSR);
    in_scan_capt = (state == CAP_DR) && (dr_sel == DR_INSCAN);
    shftdr       = (state == SH_DR)  && ((dr_sel == DR_BSR) || (dr_sel == DR_INSCAN));
    updr         = (state == UPD_DR) && (dr_sel == DR_BSR);
    test_mode    = (ir == OP_EXTEST) || (ir == OP_INTSCAN);
    TDO          = 1'b0;
    if (state == SH_IR) begin
      TDO = ir_sr[0];
    end else if (state == SH_DR) begin
      case (dr_sel)
        DR_BSR:    TDO = bsr_tdo;
        DR_INSCAN: TDO = in_scan_tdo;
        DR_IDCODE: TDO = idcode_sr[0];
        default:   TDO = bypass_ff;
      endcase
    end
  end

  assign dbg.state = state;
  assign dbg.ir    = ir;

endmodule

// File: tb/tb_tap_ctrl.sv
// Bench for tap_ctrl: directed TAP sequences plus random TMS/TDI traffic,
// every cycle compared against a table-driven model of the 1149.1 graph.
import tap_pkg::*;

module tb_tap_ctrl;

  logic     CK = 1'b0;
  logic     TRST_b, TMS, TDI, bsr_tdo, in_scan_tdo;
  logic     TDO, bsr_capt, in_scan_capt, shftdr, updr, test_mode;
  tap_dbg_t dbg;

  int n_tests = 0;
  int n_fail  = 0;

  tap_ctrl #(.IDCODE(8'hA5)) dut (
    .CK(CK), .TRST_b(TRST_b), .TMS(TMS), .TDI(TDI),
    .bsr_tdo(bsr_tdo), .in_scan_tdo(in_scan_tdo), .TDO(TDO),
    .bsr_capt(bsr_capt), .in_scan_capt(in_scan_capt), .shftdr(shftdr),
    .updr(updr), .test_mode(test_mode), .dbg(dbg)
  );

  always #5 CK = ~CK;

  // Model states numbered in listing order: TLR RTI SelDR CapDR ShDR Ex1DR
  // PauseDR Ex2DR UpdDR SelIR CapIR ShIR Ex1IR PauseIR Ex2IR UpdIR.
  int enc  [16] = '{15, 12, 7, 6, 2, 1, 3, 0, 5, 4, 14, 10, 9, 11, 8, 13};
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int ms, m_ir, m_irsr, m_byp, m_idv;
  logic last_tdo;
  int c_bcap, c_icap, c_shf, c_upd, c_follow;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; m_ir = 3; m_irsr = 1; m_byp = 0; m_idv = 8'hA5;
  endtask

  // 0=BSR 1=internal chain 2=IDCODE 3=bypass, from the opcode table.
  function automatic int sel_of(input int ir);
    if (ir == 0 || ir == 1) return 0;
    if (ir == 2) return 1;
    if (ir == 3) return 2;
    return 3;
  endfunction

  task automatic model_edge(input logic tms, input logic tdi);
    int nx, sel;
    nx  = tms ? nxt1[ms] : nxt0[ms];
    sel = sel_of(m_ir);
    if (ms == 3) begin
      if (sel == 2) m_idv = 8'hA5;
      if (sel == 3) m_byp = 0;
    end
    if (ms == 4) begin
      if (sel == 2) m_idv = (m_idv >> 1) + (int'(tdi) * 128);
      if (sel == 3) m_byp = int'(tdi);
    end
    if (ms == 15) m_ir = m_irsr;
    if (ms == 10) m_irsr = 1;
    if (ms == 11) m_irsr = (m_irsr >> 1) + (int'(tdi) * 4);
    if (nx == 0) m_ir = 3;
    ms = nx;
  endtask

  task automatic check_outputs();
    int sel, e_tdo;
    sel   = sel_of(m_ir);
    e_tdo = 0;
    if (ms == 11) e_tdo = m_irsr % 2;
    if (ms == 4) begin
      case (sel)
        0: e_tdo = int'(bsr_tdo);
        1: e_tdo = int'(in_scan_tdo);
        2: e_tdo = m_idv % 2;
        default: e_tdo = m_byp;
      endcase
    end
    check("state", dbg.state, enc[ms]);
    check("ir", dbg.ir, m_ir);
    check("tdo", TDO, e_tdo);
    check("bsr_capt", bsr_capt, (ms == 3 && sel == 0));
    check("in_scan_capt", in_scan_capt, (ms == 3 && sel == 1));
    check("shftdr", shftdr, (ms == 4 && sel <= 1));
    check("updr", updr, (ms == 8 && sel == 0));
    check("test_mode", test_mode, (m_ir == 0 || m_ir == 2));
  endtask

  task automatic step(input logic tms, input logic tdi);
    TMS = tms; TDI = tdi;
    bsr_tdo = 1'($urandom_range(0, 1));
    in_scan_tdo = 1'($urandom_range(0, 1));
    #1;
    check_outputs();
    last_tdo = TDO;
    c_bcap += int'(bsr_capt); c_icap += int'(in_scan_capt);
    c_shf  += int'(shftdr);   c_upd  += int'(updr);
    if (shftdr && TDO == bsr_tdo) c_follow++;
    @(posedge CK);
    model_edge(tms, tdi);
    #1;
  endtask

  task automatic clr_counts();
    c_bcap = 0; c_icap = 0; c_shf = 0; c_upd = 0; c_follow = 0;
  endtask

  // From RTI: load an opcode, return the captured IR bits; ends in RTI.
  task automatic load_ir(input logic [2:0] op, output logic [2:0] cap, output logic tm_upd);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 3; i++) begin
      step(i == 2, op[i]);
      cap[i] = last_tdo;
    end
    step(1, 0);
    tm_upd = test_mode;
    step(0, 0);
  endtask

  task automatic rti_to_shdr();
    step(1, 0); step(0, 0); step(0, 0);
  endtask

  logic [2:0] cap;
  logic       tm_upd;
  logic [7:0] id_bits;
  logic [4:0] byp_bits;
  logic [4:0] byp_pat;

  initial begin
    TRST_b = 1'b0; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0; in_scan_tdo = 1'b0;
    clr_counts();
    model_reset();
    repeat (2) @(posedge CK);
    #1;
    check_outputs();
    @(negedge CK);
    TRST_b = 1'b1;
    @(posedge CK);
    model_edge(1'b1, 1'b0);
    #1;

    // IDCODE straight after reset, LSB first.
    step(0, 0);
    rti_to_shdr();
    for (int i = 0; i < 8; i++) begin
      step(i == 7, 1'($urandom_range(0, 1)));
      id_bits[i] = last_tdo;
    end
    check("idcode_stream", id_bits, 8'hA5);
    step(1, 0); step(0, 0);

    // IR capture value and delayed test_mode.
    load_ir(3'b000, cap, tm_upd);
    check("ir_capture", cap, 3'b001);
    check("tm_in_updir", tm_upd, 1'b0);
    check("tm_after_updir", test_mode, 1'b1);

    // BYPASS: captured 0 then TDI one edge late, no shftdr.
    load_ir(3'b111, cap, tm_upd);
    rti_to_shdr();
    clr_counts();
    byp_pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      step(i == 4, byp_pat[i]);
      byp_bits[i] = last_tdo;
    end
    check("bypass_stream", byp_bits, 5'b11010);
    check("bypass_shftdr", c_shf, 0);
    step(1, 0); step(0, 0);

    // EXTEST capture/shift/update strobes.
    load_ir(3'b000, cap, tm_upd);
    clr_counts();
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 0); step(0, 0); step(0, 0); step(1, 0);
    step(1, 0); step(0, 0);
    check("extest_bsr_capt", c_bcap, 1);
    check("extest_shftdr", c_shf, 4);
    check("extest_updr", c_upd, 1);
    check("extest_tdo_follow", c_follow, 4);

    // INTSCAN with a 3-cycle pause.
    load_ir(3'b010, cap, tm_upd);
    clr_counts();
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(1, 0);
    step(0, 0);
    step(0, 0); step(0, 0); step(1, 0);
    step(0, 0);
    step(1, 1);
    step(1, 0); step(0, 0);
    check("intscan_capt", c_icap, 1);
    check("intscan_shftdr", c_shf, 3);
    check("intscan_updr", c_upd, 0);

    // Asynchronous reset in the middle of an IR shift.
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 0); step(0, 0);
    TMS = 1'b1;
    TRST_b = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_ir", dbg.ir, 3'b011);
    @(negedge CK);
    TRST_b = 1'b1;
    @(posedge CK);
    model_edge(1'b1, 1'b0);
    #1;

    // Five TMS=1 edges from ShDR reach TLR.
    step(0, 0);
    rti_to_shdr();
    for (int i = 0; i < 5; i++) step(1, 0);
    check("tlr_after_5", dbg.state, 4'hF);
    check("tlr_ir", dbg.ir, 3'b011);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
